// File: rtl/fifo_reader.sv
// fifo_reader: consumer side of a fifo; pops words and presents them downstream.
// Optional macro FIFO_READER_WORD_COUNT_EN enables the delivered-word counter.
module fifo_reader #(
    parameter int DATA_BITS = 10,
    parameter int CNT_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 fifo_empty_in,
    input  logic                 fifo_error_in,
    input  logic [DATA_BITS-1:0] fifo_data_in,
    input  logic                 pause_in,
    output logic                 fifo_read,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    output logic                 error_out,
    output logic [CNT_BITS-1:0]  word_count
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        HOLD,
        ERR
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   rd_d1;

    // State register; ERR is only left through reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and pop strobe; error beats enable, enable beats pause.
    always_comb begin
        state_nxt = state;
        fifo_read = 1'b0;
        if (fifo_error_in) begin
            state_nxt = ERR;
        end else begin
            unique case (state)
                IDLE:   if (enable) state_nxt = ACTIVE;
                ACTIVE: begin
                    if (!enable)       state_nxt = IDLE;
                    else if (pause_in) state_nxt = HOLD;
                end
                HOLD: begin
                    if (!enable)        state_nxt = IDLE;
                    else if (!pause_in) state_nxt = ACTIVE;
                end
                ERR:    state_nxt = ERR;
                default: state_nxt = IDLE;
            endcase
        end
        fifo_read = (state == ACTIVE) & enable & ~pause_in
                  & ~fifo_empty_in & ~fifo_error_in;
    end

    // Capture the popped word one cycle after the pop; error flag is sticky.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_d1     <= 1'b0;
            data_out  <= '0;
            valid_out <= 1'b0;
            error_out <= 1'b0;
        end else begin
            rd_d1     <= fifo_read;
            valid_out <= rd_d1;
            error_out <= error_out | fifo_error_in;
            if (rd_d1) begin
                data_out <= fifo_data_in;
            end
        end
    end

`ifdef FIFO_READER_WORD_COUNT_EN
    logic [CNT_BITS-1:0] cnt;

    // Count delivered words, wrapping at 2^CNT_BITS.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (valid_out) begin
            cnt <= cnt + CNT_BITS'(1);
        end
    end

    assign word_count = cnt;
`else
    assign word_count = '0;
`endif

endmodule
